// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - bundle layouts, branch opcodes and FSM states for the memory stage
package mem_pkg;

  localparam int DATA_W   = 24;
  localparam int OPTYPE_W = 2;
  localparam int OPCODE_W = 4;
  localparam int RC_W     = 4;
  localparam int BW       = 16 + 2 * DATA_W;
  localparam int WBW      = 12 + 2 * DATA_W;

  // EX/MEM bundle LSB offsets
  localparam int IN_RD3_LSB     = 0;
  localparam int IN_RC_LSB      = DATA_W;
  localparam int IN_REGWR_BIT   = DATA_W + 4;
  localparam int IN_MEMTOREG_BIT = DATA_W + 5;
  localparam int IN_MEMWR_BIT   = DATA_W + 6;
  localparam int IN_BRANCH_BIT  = DATA_W + 7;
  localparam int IN_NEG_BIT     = DATA_W + 8;
  localparam int IN_ZERO_BIT    = DATA_W + 9;
  localparam int IN_ALU_LSB     = DATA_W + 10;
  localparam int IN_OPCODE_LSB  = 2 * DATA_W + 10;
  localparam int IN_OPTYPE_LSB  = 2 * DATA_W + 14;

  // MEM/WB bundle LSB offsets
  localparam int OUT_RC_LSB       = 0;
  localparam int OUT_REGWR_BIT    = 4;
  localparam int OUT_MEMTOREG_BIT = 5;
  localparam int OUT_MEMDATA_LSB  = 6;
  localparam int OUT_ALU_LSB      = DATA_W + 6;
  localparam int OUT_OPCODE_LSB   = 2 * DATA_W + 6;
  localparam int OUT_OPTYPE_LSB   = 2 * DATA_W + 10;

  localparam logic [OPCODE_W-1:0] BR_AL = 4'd0;
  localparam logic [OPCODE_W-1:0] BR_EQ = 4'd1;
  localparam logic [OPCODE_W-1:0] BR_NE = 4'd2;
  localparam logic [OPCODE_W-1:0] BR_LT = 4'd3;
  localparam logic [OPCODE_W-1:0] BR_GE = 4'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - resolves branch condition from opcode and ALU flags
module branch_cond
  import mem_pkg::*;
(
  input  logic [OPCODE_W-1:0] op_code_i,
  input  logic                zero_flag_i,
  input  logic                neg_flag_i,
  input  logic                branch_flag_i,
  output logic                taken_o
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (op_code_i)
      BR_AL:   cond = 1'b1;
      BR_EQ:   cond = zero_flag_i;
      BR_NE:   cond = !zero_flag_i;
      BR_LT:   cond = neg_flag_i;
      BR_GE:   cond = !neg_flag_i;
      default: cond = 1'b0;
    endcase
  end

  assign taken_o = branch_flag_i & cond;

endmodule

// File: rtl/buffer.sv
// rtl/buffer.sv - generic pipeline register with synchronous active-high clear
module buffer #(
  parameter int Buffer_size = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [Buffer_size-1:0] d,
  output logic [Buffer_size-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: data-memory handshake, branch resolve, MEM/WB register
module mem_stage
  import mem_pkg::*;
#(
  parameter int N   = DATA_W,
  parameter int BW  = 16 + 2 * N,
  parameter int WBW = 12 + 2 * N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [BW-1:0]  bufferIn,
  input  logic           memAck,
  input  logic [N-1:0]   memRData,
  output logic           memReq,
  output logic           memWe,
  output logic [N-1:0]   memAddr,
  output logic [N-1:0]   memWData,
  output logic           stall,
  output logic           branchTaken,
  output logic [N-1:0]   branchTarget,
  output logic [15:0]    stallCount,
  output logic [WBW-1:0] bufferOut
);

  logic [OPTYPE_W-1:0] op_type;
  logic [OPCODE_W-1:0] op_code;
  logic [N-1:0]        alu_result;
  logic                zero_flag;
  logic                neg_flag;
  logic                branch_flag;
  logic                mem_write;
  logic                mem_to_reg;
  logic                reg_write;
  logic [RC_W-1:0]     rc;
  logic [N-1:0]        rd3;

  assign {op_type, op_code, alu_result, zero_flag, neg_flag, branch_flag,
          mem_write, mem_to_reg, reg_write, rc, rd3} = bufferIn;

  mem_state_e     state_q;
  logic [15:0]    stall_cnt_q;
  logic [15:0]    stall_cnt_d;
  logic           access;
  logic           is_load;
  logic           br_raw;
  logic [N-1:0]   mem_data;
  logic [WBW-1:0] wb_d;

  assign access  = mem_write | mem_to_reg;
  assign is_load = !mem_write & mem_to_reg;

  // Request stays up through ACCESS because upstream holds bufferIn frozen
  assign memReq   = !rst && (access || state_q == ACCESS);
  assign memWe    = mem_write;
  assign memAddr  = alu_result;
  assign memWData = rd3;
  assign stall    = memReq & !memAck;

  assign mem_data = (memReq && memAck && is_load) ? memRData : '0;
  assign wb_d     = stall ? '0
                          : {op_type, op_code, alu_result, mem_data, mem_to_reg, reg_write, rc};

  branch_cond u_branch_cond (
    .op_code_i     (op_code),
    .zero_flag_i   (zero_flag),
    .neg_flag_i    (neg_flag),
    .branch_flag_i (branch_flag),
    .taken_o       (br_raw)
  );

  // Hold the flush until the completion cycle so the hazard unit sees it once
  assign branchTaken  = br_raw & !stall;
  assign branchTarget = alu_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (stall)  state_q <= ACCESS;
        ACCESS:  if (memAck) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;

  buffer #(
    .Buffer_size (WBW)
  ) u_mem_wb (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (wb_d),
    .q   (bufferOut)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for the memory stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] bufferIn;
  logic        memAck;
  logic [23:0] memRData;
  logic        memReq;
  logic        memWe;
  logic [23:0] memAddr;
  logic [23:0] memWData;
  logic        stall;
  logic        branchTaken;
  logic [23:0] branchTarget;
  logic [15:0] stallCount;
  logic [59:0] bufferOut;

  int n_tests = 0;
  int n_fail  = 0;
  logic [59:0] exp_q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .bufferIn     (bufferIn),
    .memAck       (memAck),
    .memRData     (memRData),
    .memReq       (memReq),
    .memWe        (memWe),
    .memAddr      (memAddr),
    .memWData     (memWData),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .stallCount   (stallCount),
    .bufferOut    (bufferOut)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_in(input logic [1:0] ot, input logic [3:0] oc,
                                        input logic [23:0] alu, input logic z, input logic n,
                                        input logic b, input logic mw, input logic mt,
                                        input logic rw, input logic [3:0] rc,
                                        input logic [23:0] rd3);
    return {ot, oc, alu, z, n, b, mw, mt, rw, rc, rd3};
  endfunction

  function automatic logic [59:0] mk_out(input logic [63:0] bin, input logic [23:0] md);
    return {bin[63:34], md, bin[29:24]};
  endfunction

  // Drive one cycle's inputs and push the MEM/WB value expected after the edge
  task automatic drive(input logic r, input logic [63:0] bin, input logic ack,
                       input logic [23:0] rdata, input logic [59:0] exp_wb);
    rst      = r;
    bufferIn = bin;
    memAck   = ack;
    memRData = rdata;
    exp_q.push_back(exp_wb);
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check("wb", bufferOut, exp_q.pop_front());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] nop, ld, st, in;

    nop = mk_in(2'd0, 4'd0, 24'h00ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 24'h0);
    ld  = mk_in(2'd1, 4'd2, 24'h000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 24'h0);
    st  = mk_in(2'd2, 4'd3, 24'h000200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 24'h00FF00);

    // reset with a load on the input: request must be masked
    @(posedge clk); #1;
    drive(1'b1, ld, 1'b0, 24'h0, 60'h0);
    check("rst_memreq", memReq, 0);
    check("rst_stall", stall, 0);
    cycle();
    check("rst_stallcount", stallCount, 0);

    // non-memory op
    drive(1'b0, nop, 1'b0, 24'h0, mk_out(nop, 24'h0));
    check("nop_stall", stall, 0);
    check("nop_memreq", memReq, 0);
    cycle();
    check("nop_alu", bufferOut[53:30], 24'h00ABCD);
    check("nop_rc", bufferOut[3:0], 4'd5);
    check("nop_memdata", bufferOut[29:6], 0);

    // load acked on the third request cycle
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, ld, 1'b0, 24'h0, 60'h0);
      check("ld_req", memReq, 1);
      check("ld_addr", memAddr, 24'h000100);
      check("ld_we", memWe, 0);
      check("ld_stall", stall, 1);
      cycle();
    end
    drive(1'b0, ld, 1'b1, 24'h123456, mk_out(ld, 24'h123456));
    check("ld_ack_req", memReq, 1);
    check("ld_ack_stall", stall, 0);
    cycle();
    check("ld_memdata", bufferOut[29:6], 24'h123456);
    check("ld_stallcount", stallCount, 2);

    // zero-wait store, back-to-back with zero-wait load
    drive(1'b0, st, 1'b1, 24'hDEAD00, mk_out(st, 24'h0));
    check("st_we", memWe, 1);
    check("st_wdata", memWData, 24'h00FF00);
    check("st_stall", stall, 0);
    check("st_req", memReq, 1);
    cycle();
    drive(1'b0, ld, 1'b1, 24'h0ABCDE, mk_out(ld, 24'h0ABCDE));
    check("ld0_stall", stall, 0);
    cycle();
    check("zw_stallcount", stallCount, 2);

    // ack with no request is ignored
    drive(1'b0, nop, 1'b1, 24'hFFFFFF, mk_out(nop, 24'h0));
    check("spur_req", memReq, 0);
    cycle();

    // branches: {opcode, zero, neg, expected taken}
    begin
      logic [6:0] br_tab [6];
      br_tab = '{{4'd1, 1'b1, 1'b0, 1'b1}, {4'd2, 1'b1, 1'b0, 1'b0}, {4'd3, 1'b0, 1'b1, 1'b1},
                 {4'd7, 1'b1, 1'b1, 1'b0}, {4'd4, 1'b0, 1'b0, 1'b1}, {4'd0, 1'b0, 1'b0, 1'b1}};
      foreach (br_tab[i]) begin
        in = mk_in(2'd3, br_tab[i][6:3], 24'h000400 + 24'(i), br_tab[i][2], br_tab[i][1],
                   1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0);
        drive(1'b0, in, 1'b0, 24'h0, mk_out(in, 24'h0));
        check($sformatf("br%0d_taken", i), branchTaken, br_tab[i][0]);
        check($sformatf("br%0d_target", i), branchTarget, 24'h000400 + 24'(i));
        cycle();
      end
    end

    // branch riding on a stalled load: flush only on completion
    in = mk_in(2'd3, 4'd0, 24'h000500, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 24'h0);
    drive(1'b0, in, 1'b0, 24'h0, 60'h0);
    check("brst_suppr", branchTaken, 0);
    cycle();
    drive(1'b0, in, 1'b1, 24'h00AAAA, mk_out(in, 24'h00AAAA));
    check("brst_taken", branchTaken, 1);
    cycle();
    check("brst_stallcount", stallCount, 3);

    // reset in the second ACCESS cycle
    drive(1'b0, ld, 1'b0, 24'h0, 60'h0);
    cycle();
    drive(1'b1, ld, 1'b0, 24'h0, 60'h0);
    check("rstacc_req", memReq, 0);
    cycle();
    check("rstacc_stallcount", stallCount, 0);
    drive(1'b0, nop, 1'b1, 24'h654321, mk_out(nop, 24'h0));
    check("rstacc_idle_req", memReq, 0);
    check("rstacc_idle_stall", stall, 0);
    cycle();

    // long stall: saturation of the stall counter
    rst = 1'b0; bufferIn = ld; memAck = 1'b0; memRData = 24'h0;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", stallCount, 16'hFFFE);
    repeat (4466) @(posedge clk);
    #1;
    check("sat_ffff", stallCount, 16'hFFFF);
    check("sat_bubble", bufferOut, 0);
    drive(1'b0, ld, 1'b1, 24'h111111, mk_out(ld, 24'h111111));
    cycle();
    check("sat_hold", stallCount, 16'hFFFF);

    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
